// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
// Sizes, FSM states and the access-size byte count live here.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        WR0  = 3'd2,
        RD1  = 3'd3,
        WR1  = 3'd4,
        RESP = 3'd5
    } lsu_state_e;

    // Size code 2'b11 is handled as a full word.
    function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
        logic [2:0] nb;
        case (sz)
            2'b00:   nb = 3'd1;
            2'b01:   nb = 3'd2;
            default: nb = 3'd4;
        endcase
        return nb;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: store merge into an old word and
// load extraction plus sign/zero extension from a two-word window.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] buf0_i,
    input  logic [31:0] buf1_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        part_i,
    input  logic        uns_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [2:0]  nb;
    logic [3:0]  k;
    logic [31:0] raw;

    assign nb = size_nbytes(size_i);

    // Lane i of word `part` holds request byte (part*4 + i - off).
    always_comb begin
        merged_o = part_i ? buf1_i : buf0_i;
        k        = '0;
        for (int i = 0; i < 4; i++) begin
            k = {1'b0, part_i, 2'(i)} - {2'b00, off_i};
            if (k < {1'b0, nb}) begin
                merged_o[8*i +: 8] = data_i[8*k[1:0] +: 8];
            end
        end
    end

    always_comb begin
        case (off_i)
            2'd0:    raw = buf0_i;
            2'd1:    raw = {buf1_i[7:0],  buf0_i[31:8]};
            2'd2:    raw = {buf1_i[15:0], buf0_i[31:16]};
            default: raw = {buf1_i[23:0], buf0_i[31:24]};
        endcase
    end

    always_comb begin
        case (size_i)
            2'(SZ_B): load_o = {{24{~uns_i & raw[7]}}, raw[7:0]};
            2'(SZ_H): load_o = {{16{~uns_i & raw[15]}}, raw[15:0]};
            default:  load_o = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator for a single-port word memory without byte enables:
// read-modify-write for sub-word stores and word-boundary split handling.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [WIDTH-1:0]      req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [WIDTH-1:0]      rsp_rdata_o,
    output logic                  mem_read_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [WIDTH-1:0]      mem_rdata_i,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [WIDTH-1:0]      mem_wdata_o
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     buf0_q, buf0_d;
    logic [31:0]     buf1_q, buf1_d;

    logic [ADDR_WIDTH-1:0] w0;
    logic [ADDR_WIDTH-1:0] w1;
    logic [3:0]            span;
    logic                  split;
    logic                  full_word;
    logic [31:0]           merged;
    logic [31:0]           load_data;

    assign w0    = addr_q[ADDR_WIDTH+1:2];
    assign w1    = w0 + ADDR_WIDTH'(1);
    assign span  = {2'b00, addr_q[1:0]} + {1'b0, size_nbytes(size_q)};
    assign split = span > 4'd4;

    assign full_word = (req_addr_i[1:0] == 2'b00)
                     && (size_nbytes(req_size_i) == 3'd4);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    uns_d   = req_unsigned_i;
                    wdata_d = req_wdata_i;
                    buf0_d  = '0;
                    buf1_d  = '0;
                    state_d = (req_we_i && full_word) ? WR0 : RD0;
                end
            end
            RD0: begin
                buf0_d = mem_rdata_i;
                if (we_q)       state_d = WR0;
                else if (split) state_d = RD1;
                else            state_d = RESP;
            end
            WR0: state_d = split ? RD1 : RESP;
            RD1: begin
                buf1_d  = mem_rdata_i;
                state_d = we_q ? WR1 : RESP;
            end
            WR1:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
        end
    end

    lsu_byte_lane u_lane (
        .buf0_i   (buf0_q),
        .buf1_i   (buf1_q),
        .data_i   (wdata_q),
        .off_i    (addr_q[1:0]),
        .size_i   (size_q),
        .part_i   (state_q == WR1),
        .uns_i    (uns_q),
        .merged_o (merged),
        .load_o   (load_data)
    );

    // Writes are suppressed while reset is asserted so a dropped request
    // never commits a second half.
    always_comb begin
        req_ready_o = (state_q == IDLE) && !rst_i;
        mem_read_o  = (state_q == RD0) || (state_q == RD1);
        mem_raddr_o = '0;
        if (state_q == RD0) mem_raddr_o = w0;
        if (state_q == RD1) mem_raddr_o = w1;
        mem_write_o = ((state_q == WR0) || (state_q == WR1)) && !rst_i;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        if (mem_write_o) begin
            mem_waddr_o = (state_q == WR1) ? w1 : w0;
            mem_wdata_o = merged;
        end
        rsp_valid_o = (state_q == RESP);
        rsp_rdata_o = (rsp_valid_o && !we_q) ? load_data : '0;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with an async-read, sync-write memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_uns = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_read;
    logic [29:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_write;
    logic [29:0] mem_waddr;
    logic [31:0] mem_wdata;

    logic [31:0] mem [0:15];
    logic        pk_en = 1'b0;
    logic [3:0]  pk_a = '0;
    logic [31:0] pk_d = '0;

    int n_cmp = 0;
    int n_err = 0;
    int lat, nrd, nwr, got;
    logic [31:0] rdat;
    logic [29:0] ralog [0:1];

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .mem_read_o     (mem_read),
        .mem_raddr_o    (mem_raddr),
        .mem_rdata_i    (mem_rdata),
        .mem_write_o    (mem_write),
        .mem_waddr_o    (mem_waddr),
        .mem_wdata_o    (mem_wdata)
    );

    assign mem_rdata = mem[mem_raddr[3:0]];

    always @(posedge clk) begin
        if (pk_en) mem[pk_a] <= pk_d;
        else if (mem_write) mem[mem_waddr[3:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    task automatic issue(input logic we, input logic [31:0] a,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_size  = sz;
        req_uns   = uns;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat  = 0;
        nrd  = 0;
        nwr  = 0;
        got  = 0;
        rdat = '0;
        ralog[0] = '1;
        ralog[1] = '1;
        for (int c = 1; c <= 20 && got == 0; c++) begin
            @(negedge clk);
            if (mem_read) begin
                if (nrd < 2) ralog[nrd] = mem_raddr;
                nrd++;
            end
            if (mem_write) nwr++;
            if (rsp_valid) begin
                got  = 1;
                lat  = c;
                rdat = rsp_rdata;
            end
        end
        if (got == 0) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rw", {30'd0, mem_read, mem_write}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        poke(4'd0, 32'h80332211);
        issue(1'b0, 32'h3, 2'b00, 1'b0, '0);
        chk("lb_data", rdat, 32'hFFFFFF80);
        chk("lb_lat", lat, 2);
        chk("lb_nrd", nrd, 1);
        issue(1'b0, 32'h3, 2'b00, 1'b1, '0);
        chk("lbu_data", rdat, 32'h00000080);

        poke(4'd0, 32'h44332211);
        issue(1'b1, 32'h2, 2'b01, 1'b0, 32'h0000BEEF);
        chk("sh_mem0", mem[0], 32'hBEEF2211);
        chk("sh_nrd", nrd, 1);
        chk("sh_nwr", nwr, 1);
        chk("sh_lat", lat, 3);
        chk("sh_rdata", rdat, 32'd0);

        poke(4'd0, 32'h44332211);
        poke(4'd1, 32'h88776655);
        issue(1'b0, 32'h2, 2'b10, 1'b0, '0);
        chk("split_ld", rdat, 32'h66554433);
        chk("split_ld_lat", lat, 3);
        chk("split_ld_nrd", nrd, 2);

        issue(1'b1, 32'h3, 2'b10, 1'b0, 32'hAABBCCDD);
        chk("split_st_m0", mem[0], 32'hDD332211);
        chk("split_st_m1", mem[1], 32'h88AABBCC);
        chk("split_st_nwr", nwr, 2);
        chk("split_st_lat", lat, 5);

        issue(1'b1, 32'h8, 2'b10, 1'b0, 32'h12345678);
        chk("sw_mem2", mem[2], 32'h12345678);
        chk("sw_nrd", nrd, 0);
        chk("sw_lat", lat, 2);

        poke(4'd15, 32'h5A000000);
        poke(4'd0, 32'h00000081);
        issue(1'b0, 32'hFFFFFFFF, 2'b01, 1'b0, '0);
        chk("wrap_data", rdat, 32'hFFFF815A);
        chk("wrap_ra0", 32'(ralog[0]), 32'h3FFFFFFF);
        chk("wrap_ra1", 32'(ralog[1]), 32'h0);
        chk("wrap_lat", lat, 3);

        poke(4'd0, 32'h44332211);
        poke(4'd1, 32'h88776655);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h3;
        req_size  = 2'b10;
        req_uns   = 1'b0;
        req_wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nwr = 0;
        got = 0;
        @(negedge clk);
        @(negedge clk);
        if (mem_write) nwr++;
        @(negedge clk);
        chk("rst_mid_rd1", {31'd0, mem_read}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) chk("rst_rel_ready", 32'(req_ready), 32'd1);
            if (rsp_valid) got++;
            if (mem_write) nwr++;
        end
        chk("rst_mid_m0", mem[0], 32'hDD332211);
        chk("rst_mid_m1", mem[1], 32'h88776655);
        chk("rst_mid_nwr", nwr, 1);
        chk("rst_mid_rsp", got, 0);

        issue(1'b0, 32'h0, 2'b10, 1'b0, '0);
        chk("post_rst_ld", rdat, 32'hDD332211);
        chk("post_rst_lat", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
